// File: rtl/md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// MDOp encodings, controller state type and default latencies.
package md_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_compute.sv
// Combinational datapath: 64-bit product for mult/multu, {remainder,quotient}
// for div/divu, plus a divide-by-zero flag.
module md_compute
  import md_pkg::*;
(
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic signed [32:0] sa, sb, sb_safe, q, r;
  logic               is_signed;
  logic               unused_msb;

  assign sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign uprod = {32'b0, A} * {32'b0, B};

  // 33-bit signed divide: 0x80000000 / -1 yields +2^31, whose low word is
  // 0x80000000 with no overflow trap; divu zero-extends into the same path.
  assign is_signed   = (MDOp == MD_DIV);
  assign sa          = {is_signed & A[31], A};
  assign sb          = {is_signed & B[31], B};
  assign div_by_zero = (B == 32'd0);
  assign sb_safe     = div_by_zero ? 33'sd1 : sb;
  assign q           = sa / sb_safe;
  assign r           = sa % sb_safe;
  assign unused_msb  = q[32] ^ r[32];

  always_comb begin
    hi = '0;
    lo = '0;
    case (MDOp)
      MD_MULT:         {hi, lo} = sprod;
      MD_MULTU:        {hi, lo} = uprod;
      MD_DIV, MD_DIVU: begin
        hi = r[31:0];
        lo = q[31:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: fixed-latency busy window, result written to HI/LO
// together at the end of the window; mthi/mtlo write immediately.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  md_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] res_hi, res_lo, res_hi_n, res_lo_n, hi_n, lo_n;
  logic        dz, dz_n;
  logic [31:0] c_hi, c_lo;
  logic        c_dz;

  md_compute u_compute (
    .MDOp        (MDOp),
    .A           (A),
    .B           (B),
    .hi          (c_hi),
    .lo          (c_lo),
    .div_by_zero (c_dz)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    res_hi_n = res_hi;
    res_lo_n = res_lo;
    dz_n     = dz;
    hi_n     = HI;
    lo_n     = LO;
    case (state)
      IDLE: if (Start) begin
        case (MDOp)
          MD_MULT, MD_MULTU: begin
            res_hi_n = c_hi;
            res_lo_n = c_lo;
            dz_n     = 1'b0;
            cnt_n    = CW'(MULT_CYCLES - 1);
            state_n  = MULT;
          end
          MD_DIV, MD_DIVU: begin
            res_hi_n = c_hi;
            res_lo_n = c_lo;
            dz_n     = c_dz;
            cnt_n    = CW'(DIV_CYCLES - 1);
            state_n  = DIV;
          end
          MD_MTHI: hi_n = A;
          MD_MTLO: lo_n = A;
          default: ;
        endcase
      end
      MULT, DIV: begin
        if (cnt != '0) cnt_n = cnt - CW'(1);
        else begin
          state_n = IDLE;
          // divide by zero burns the full window but leaves HI/LO alone
          if (!dz) begin
            hi_n = res_hi;
            lo_n = res_lo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      dz     <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      res_hi <= res_hi_n;
      res_lo <= res_lo_n;
      dz     <= dz_n;
      HI     <= hi_n;
      LO     <= lo_n;
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, register moves,
// divide by zero, ignored Start, back-to-back issue and mid-op reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an op in the current cycle; check Busy over cycles 1..n, then
  // Busy low and the result in cycle n+1 (left current for a back-to-back issue).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] eh, input logic [31:0] el);
    Start = 1'b1; MDOp = op; A = a; B = b;
    step();
    Start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      chk({tag, "_busy"}, {31'b0, Busy}, 32'd1);
      step();
    end
    chk({tag, "_idle"}, {31'b0, Busy}, 32'd0);
    chk({tag, "_hi"}, HI, eh);
    chk({tag, "_lo"}, LO, el);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = '0; A = '0; B = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);

    run_op("mult",  3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    run_op("div",   3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);

    // mthi then mtlo on consecutive cycles
    Start = 1'b1; MDOp = 3'd4; A = 32'h12345678;
    step();
    chk("mthi_busy", {31'b0, Busy}, 32'd0);
    chk("mthi_hi", HI, 32'h12345678);
    MDOp = 3'd5; A = 32'h9ABCDEF0;
    step();
    Start = 1'b0;
    chk("mtlo_busy", {31'b0, Busy}, 32'd0);
    chk("mtlo_hi", HI, 32'h12345678);
    chk("mtlo_lo", LO, 32'h9ABCDEF0);

    run_op("divz", 3'd2, 32'd5, 32'd0, 10, 32'h12345678, 32'h9ABCDEF0);

    // reserved MDOp is a no-op
    Start = 1'b1; MDOp = 3'd6; A = 32'h55555555; B = 32'd7;
    step();
    Start = 1'b0;
    chk("rsv_busy", {31'b0, Busy}, 32'd0);
    chk("rsv_hi", HI, 32'h12345678);
    chk("rsv_lo", LO, 32'h9ABCDEF0);

    // Start during a mult (busy cycle 2) must be ignored
    Start = 1'b1; MDOp = 3'd0; A = 32'd7; B = 32'd6;
    step();
    Start = 1'b0;
    chk("ign_busy1", {31'b0, Busy}, 32'd1);
    step();
    Start = 1'b1; MDOp = 3'd5; A = 32'hDEADBEEF;
    step();
    Start = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      chk("ign_busy", {31'b0, Busy}, 32'd1);
      chk("ign_lo_hold", LO, 32'h9ABCDEF0);
      step();
    end
    chk("ign_idle", {31'b0, Busy}, 32'd0);
    chk("ign_hi", HI, 32'h0);
    chk("ign_lo", LO, 32'd42);

    // issued in the cycle Busy falls: back-to-back acceptance
    run_op("b2b", 3'd1, 32'h00010000, 32'h00010000, 5, 32'h00000001, 32'h00000000);

    // reset during div busy cycle 4
    Start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd3;
    step();
    Start = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    chk("rmid_busy4", {31'b0, Busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid_busy", {31'b0, Busy}, 32'd0);
    chk("rmid_hi", HI, 32'h0);
    chk("rmid_lo", LO, 32'h0);
    for (int i = 0; i < 10; i++) step();
    chk("rmid_late_busy", {31'b0, Busy}, 32'd0);
    chk("rmid_late_hi", HI, 32'h0);
    chk("rmid_late_lo", LO, 32'h0);

    run_op("ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
